// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
package pipe_ctrl_pkg;

  localparam int REG_W_DEF      = 5;
  localparam int MULDIV_LAT_DEF = 32;
  localparam int MD_CNT_W       = 6;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MD_STALL = 2'd2
  } md_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_muldiv_occupancy.sv
// rtl/pipeline_hazard_ctrl_muldiv_occupancy.sv - mul/div occupancy FSM and latency counter
module muldiv_occupancy
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic hz_i,
  input  logic abort_i,
  output logic busy_o
);

  localparam logic [MD_CNT_W-1:0] LAT_M1 = MD_CNT_W'(MULDIV_LAT - 1);

  md_state_e           state_q;
  logic [MD_CNT_W-1:0] cnt_q;
  logic                busy_q;

  // Occupancy FSM: counts down the unit latency, tracks whether ID is held behind it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (abort_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (start_i) begin
            state_q <= MD_BUSY;
            cnt_q   <= LAT_M1;
            busy_q  <= 1'b1;
          end
        end
        MD_BUSY, MD_STALL: begin
          if (cnt_q == '0) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - MD_CNT_W'(1);
            state_q <= hz_i ? MD_STALL : MD_BUSY;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline hazard/sequencing controller; HAZARD_STATS_EN adds stall/flush counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int REG_W      = REG_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_MulDiv,
  input  logic             ID_ReadsHiLo,
  input  logic             ID_BranchTaken,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rt,
  input  logic             EX_Exception,
  output logic             PCWrite,
  output logic             IFDWrite,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             EX_Flush,
  output logic             MD_Start,
  output logic             MD_Abort,
  output logic             MD_Busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      Stall_Count,
  output logic [31:0]      Flush_Count
`endif
);

  if (MULDIV_LAT < 2 || MULDIV_LAT > 63) begin : g_lat_range
    $error("MULDIV_LAT must be within 2..63");
  end

  logic md_busy;
  logic load_use;
  logic md_hz;
  logic stall;
  logic md_start;

  assign load_use = EX_MemRead & (EX_Rt != '0) &
                    ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));
  assign md_hz    = md_busy & (ID_MulDiv | ID_ReadsHiLo);
  assign stall    = load_use | md_hz;
  assign md_start = ID_MulDiv & ~md_busy & ~load_use & ~EX_Exception & ~Reset;

  muldiv_occupancy #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_occ (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .start_i (md_start),
    .hz_i    (md_hz),
    .abort_i (EX_Exception),
    .busy_o  (md_busy)
  );

  // Priority resolution: exception flush, then stall, then branch squash, then flow.
  always_comb begin
    PCWrite  = 1'b1;
    IFDWrite = 1'b1;
    IF_Flush = 1'b0;
    ID_Flush = 1'b0;
    EX_Flush = 1'b0;
    MD_Abort = 1'b0;
    MD_Start = md_start;
    MD_Busy  = md_busy & ~Reset;
    if (Reset) begin
      // Only IFDWrite stays high so the stage registers load their cleared values.
      PCWrite  = 1'b0;
    end else if (EX_Exception) begin
      IF_Flush = 1'b1;
      ID_Flush = 1'b1;
      EX_Flush = 1'b1;
      MD_Abort = md_busy;
    end else if (stall) begin
      // A pending branch is dropped here; it resolves again once ID is released.
      PCWrite  = 1'b0;
      IFDWrite = 1'b0;
      ID_Flush = 1'b1;
    end else if (ID_BranchTaken) begin
      IF_Flush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters for stall and fetch-squash cycles.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (stall && !EX_Exception && (Stall_Count != 32'hFFFF_FFFF)) begin
        Stall_Count <= Stall_Count + 32'd1;
      end
      if (IF_Flush && (Flush_Count != 32'hFFFF_FFFF)) begin
        Flush_Count <= Flush_Count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int LAT = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic       ID_UsesRt, ID_MulDiv, ID_ReadsHiLo, ID_BranchTaken;
  logic       EX_MemRead, EX_Exception;
  logic       PCWrite, IFDWrite, IF_Flush, ID_Flush, EX_Flush;
  logic       MD_Start, MD_Abort, MD_Busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] Stall_Count, Flush_Count;
`endif

  always #5 Clock = ~Clock;

  pipeline_hazard_ctrl #(
    .MULDIV_LAT (LAT),
    .REG_W      (5)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .ID_MulDiv      (ID_MulDiv),
    .ID_ReadsHiLo   (ID_ReadsHiLo),
    .ID_BranchTaken (ID_BranchTaken),
    .EX_MemRead     (EX_MemRead),
    .EX_Rt          (EX_Rt),
    .EX_Exception   (EX_Exception),
    .PCWrite        (PCWrite),
    .IFDWrite       (IFDWrite),
    .IF_Flush       (IF_Flush),
    .ID_Flush       (ID_Flush),
    .EX_Flush       (EX_Flush),
    .MD_Start       (MD_Start),
    .MD_Abort       (MD_Abort),
    .MD_Busy        (MD_Busy)
`ifdef HAZARD_STATS_EN
    ,
    .Stall_Count    (Stall_Count),
    .Flush_Count    (Flush_Count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference state: cycles of mul/div occupancy left, and event counts.
  int          busy_left   = 0;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;
  bit          stats_valid = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_load_use();
    return EX_MemRead && (EX_Rt != 0) &&
           ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
  endfunction

  function automatic logic m_md_hz();
    return (busy_left > 0) && (ID_MulDiv || ID_ReadsHiLo);
  endfunction

  // {PCWrite, IFDWrite, IF_Flush, ID_Flush, EX_Flush, MD_Start, MD_Abort, MD_Busy}
  function automatic logic [7:0] model_out();
    logic busy, st, ms;
    busy = (busy_left > 0);
    st   = m_load_use() || m_md_hz();
    ms   = ID_MulDiv && !busy && !m_load_use() && !EX_Exception;
    if (Reset)               return 8'b0100_0000;
    else if (EX_Exception)   return {5'b11111, 1'b0, busy, busy};
    else if (st)             return {5'b00010, 1'b0, 1'b0, busy};
    else if (ID_BranchTaken) return {5'b11100, ms, 1'b0, busy};
    else                     return {5'b11000, ms, 1'b0, busy};
  endfunction

  task automatic clear_in();
    Reset = 0; ID_Rs = 0; ID_Rt = 0; EX_Rt = 0;
    ID_UsesRt = 0; ID_MulDiv = 0; ID_ReadsHiLo = 0; ID_BranchTaken = 0;
    EX_MemRead = 0; EX_Exception = 0;
  endtask

  task automatic settle(input string tag);
    #4;
    check_eq(tag, {PCWrite, IFDWrite, IF_Flush, ID_Flush, EX_Flush, MD_Start, MD_Abort, MD_Busy},
             model_out());
`ifdef HAZARD_STATS_EN
    if (stats_valid) begin
      check_eq({tag, "_stallcnt"}, Stall_Count, m_stall_cnt);
      check_eq({tag, "_flushcnt"}, Flush_Count, m_flush_cnt);
    end
`endif
  endtask

  task automatic tick();
    logic [7:0] e;
    logic       st;
    e  = model_out();
    st = m_load_use() || m_md_hz();
    @(posedge Clock);
    if (Reset) begin
      busy_left   = 0;
      m_stall_cnt = '0;
      m_flush_cnt = '0;
    end else begin
      if (st && !EX_Exception && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (e[5] && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
      if (EX_Exception)   busy_left = 0;
      else if (e[2])      busy_left = LAT;
      else if (busy_left > 0) busy_left--;
    end
    stats_valid = 1;
    #1;
  endtask

  initial begin
    clear_in();
    Reset = 1;
    settle("reset0");
    check_eq("reset_ifdwrite", IFDWrite, 1'b1);
    check_eq("reset_pcwrite", PCWrite, 1'b0);
    tick();
    settle("reset1");
    tick();

    // Load-use hazard then release
    clear_in(); EX_MemRead = 1; EX_Rt = 8; ID_Rs = 8;
    settle("lu");
    check_eq("lu_pcwrite", PCWrite, 1'b0);
    check_eq("lu_ifdwrite", IFDWrite, 1'b0);
    check_eq("lu_idflush", ID_Flush, 1'b1);
    tick();
    clear_in(); ID_Rs = 8;
    settle("lu_after");
    check_eq("lu_after_pcwrite", PCWrite, 1'b1);
    check_eq("lu_after_idflush", ID_Flush, 1'b0);
    tick();
    clear_in(); EX_MemRead = 1; EX_Rt = 0; ID_Rs = 0;
    settle("lu_r0");
    check_eq("lu_r0_pcwrite", PCWrite, 1'b1);
    tick();

    // Branch squash, and branch losing to a stall
    clear_in(); ID_BranchTaken = 1;
    settle("br");
    check_eq("br_ifflush", IF_Flush, 1'b1);
    check_eq("br_idflush", ID_Flush, 1'b0);
    tick();
    clear_in(); ID_BranchTaken = 1; EX_MemRead = 1; EX_Rt = 5; ID_Rt = 5; ID_UsesRt = 1;
    settle("br_lu");
    check_eq("br_lu_ifflush", IF_Flush, 1'b0);
    check_eq("br_lu_pcwrite", PCWrite, 1'b0);
    tick();

    // Mul/div latency with dependent mfhi
    clear_in(); ID_MulDiv = 1;
    settle("md_start");
    check_eq("md_start_pulse", MD_Start, 1'b1);
    tick();
    for (int i = 0; i < LAT; i++) begin
      clear_in(); ID_ReadsHiLo = 1;
      settle("md_hold");
      check_eq("md_hold_pcwrite", PCWrite, 1'b0);
      check_eq("md_hold_busy", MD_Busy, 1'b1);
      tick();
    end
    settle("md_release");
    check_eq("md_release_pcwrite", PCWrite, 1'b1);
    check_eq("md_release_busy", MD_Busy, 1'b0);
    tick();

    // Back-to-back mult
    clear_in(); ID_MulDiv = 1;
    settle("b2b_first");
    tick();
    for (int i = 0; i < LAT; i++) begin
      settle("b2b_hold");
      check_eq("b2b_hold_start", MD_Start, 1'b0);
      check_eq("b2b_hold_pcwrite", PCWrite, 1'b0);
      tick();
    end
    settle("b2b_second");
    check_eq("b2b_second_start", MD_Start, 1'b1);
    tick();

    // Exception two cycles into an operation
    clear_in();
    settle("exc_pre");
    tick();
    EX_Exception = 1;
    settle("exc");
    check_eq("exc_flushes", {IF_Flush, ID_Flush, EX_Flush}, 3'b111);
    check_eq("exc_abort", MD_Abort, 1'b1);
    tick();
    clear_in();
    settle("exc_post");
    check_eq("exc_post_busy", MD_Busy, 1'b0);
    tick();

    // Reset during MD_STALL
    clear_in(); ID_MulDiv = 1;
    settle("rst_md_start");
    tick();
    clear_in(); ID_ReadsHiLo = 1;
    settle("rst_md_stall");
    tick();
    Reset = 1;
    settle("rst_mid");
    tick();
    clear_in();
    settle("rst_post");
    check_eq("rst_post_pcwrite", PCWrite, 1'b1);
    check_eq("rst_post_busy", MD_Busy, 1'b0);
`ifdef HAZARD_STATS_EN
    check_eq("rst_post_stallcnt_zero", Stall_Count, 32'd0);
    check_eq("rst_post_flushcnt_zero", Flush_Count, 32'd0);
`endif
    tick();

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      Reset          = ($urandom_range(0, 149) == 0);
      ID_Rs          = 5'($urandom_range(0, 3));
      ID_Rt          = 5'($urandom_range(0, 3));
      EX_Rt          = 5'($urandom_range(0, 3));
      ID_UsesRt      = ($urandom_range(0, 1) == 1);
      ID_MulDiv      = ($urandom_range(0, 5) == 0);
      ID_ReadsHiLo   = ($urandom_range(0, 5) == 0);
      ID_BranchTaken = ($urandom_range(0, 4) == 0);
      EX_MemRead     = ($urandom_range(0, 2) == 0);
      EX_Exception   = ($urandom_range(0, 24) == 0);
      settle("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
